// File: rtl/laser_tx_if.sv
// laser_tx_if: handshake/data bundle between the packet source (makepacket
// side, master) and the optical transmitter (laser_tx, slave).
//   start      : master -> slave, request to send (level-sampled)
//   packet     : master -> slave, PACKET_W-bit payload, captured on accept
//   busy       : slave -> master, frame + gap in progress
//   laser_out  : slave -> pins,   registered laser drive (1 = on)
//   packetsent : slave -> master, one-cycle end-of-frame pulse
interface laser_tx_if #(
    parameter int PACKET_W = 288
);
    logic                start;
    logic [PACKET_W-1:0] packet;
    logic                busy;
    logic                laser_out;
    logic                packetsent;

    modport master (
        output start, packet,
        input  busy, laser_out, packetsent
    );

    modport slave (
        input  start, packet,
        output busy, laser_out, packetsent
    );
endinterface

// File: rtl/laser_tx.sv
// laser_tx: optical-link transmitter. Accepts one packet, sends a 16-bit
// header then the payload MSB first, Manchester-encoded (1 = on/off,
// 0 = off/on), followed by GAP_BITS bit-times of laser-off. packetsent
// pulses for one cycle when the gap ends.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : laser_tx_if.slave (start, packet in; busy, laser_out,
//           packetsent out)
// HALF_BIT >= 1, GAP_BITS >= 1, PACKET_W >= 2.
module laser_tx #(
    parameter int          PACKET_W = 288,
    parameter int          HALF_BIT = 325,
    parameter logic [15:0] HEADER   = 16'hAA7E,
    parameter int          GAP_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    laser_tx_if.slave   bus
);
    // Counter widths are kept at least 1 bit so degenerate parameter
    // choices (HALF_BIT=1, GAP_BITS=1) still elaborate.
    localparam int HW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam int BW = ($clog2(PACKET_W) > 4) ? $clog2(PACKET_W) : 5;

    localparam logic [HW-1:0] HB_LAST  = HW'(HALF_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);
    localparam logic [BW-1:0] HDR_LAST = BW'(15);
    localparam logic [BW-1:0] PAY_LAST = BW'(PACKET_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_GAP} state_t;

    state_t              state_q;
    logic [HW-1:0]       hb_q;       // cycle within the current half-bit
    logic                ph_q;       // 0 = first half, 1 = second half
    logic [BW-1:0]       bit_q;      // bit index within header/payload
    logic [GW-1:0]       gap_q;      // gap bit-times elapsed
    logic [15:0]         hdr_q;
    logic [PACKET_W-1:0] sh_q;
    logic                laser_q;
    logic                busy_q;
    logic                sent_q;

    // Bit currently on the wire; the MSB of whichever register is active.
    logic cur_bit;
    assign cur_bit = (state_q == S_HEADER) ? hdr_q[15] : sh_q[PACKET_W-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            hb_q    <= '0;
            ph_q    <= 1'b0;
            bit_q   <= '0;
            gap_q   <= '0;
            hdr_q   <= '0;
            sh_q    <= '0;
            laser_q <= 1'b0;
            busy_q  <= 1'b0;
            sent_q  <= 1'b0;
        end else begin
            sent_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    laser_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (bus.start) begin
                        // First half of header MSB goes out on the very next
                        // cycle, so drive it now.
                        state_q <= S_HEADER;
                        sh_q    <= bus.packet;
                        hdr_q   <= HEADER;
                        laser_q <= HEADER[15];
                        busy_q  <= 1'b1;
                        hb_q    <= '0;
                        ph_q    <= 1'b0;
                        bit_q   <= '0;
                        gap_q   <= '0;
                    end
                end
                default: begin
                    if (hb_q != HB_LAST) begin
                        hb_q <= hb_q + 1'b1;
                    end else begin
                        hb_q <= '0;
                        if (!ph_q) begin
                            // Mid-bit transition: second half is the inverse.
                            ph_q <= 1'b1;
                            if (state_q != S_GAP) laser_q <= ~cur_bit;
                        end else begin
                            // End of bit: advance and present next bit's
                            // first half.
                            ph_q <= 1'b0;
                            case (state_q)
                                S_HEADER: begin
                                    if (bit_q == HDR_LAST) begin
                                        bit_q   <= '0;
                                        state_q <= S_PAYLOAD;
                                        laser_q <= sh_q[PACKET_W-1];
                                    end else begin
                                        bit_q   <= bit_q + 1'b1;
                                        hdr_q   <= {hdr_q[14:0], 1'b0};
                                        laser_q <= hdr_q[14];
                                    end
                                end
                                S_PAYLOAD: begin
                                    if (bit_q == PAY_LAST) begin
                                        bit_q   <= '0;
                                        state_q <= S_GAP;
                                        laser_q <= 1'b0;
                                    end else begin
                                        bit_q   <= bit_q + 1'b1;
                                        sh_q    <= {sh_q[PACKET_W-2:0], 1'b0};
                                        laser_q <= sh_q[PACKET_W-2];
                                    end
                                end
                                default: begin // S_GAP
                                    laser_q <= 1'b0;
                                    if (gap_q == GAP_LAST) begin
                                        gap_q   <= '0;
                                        state_q <= S_IDLE;
                                        busy_q  <= 1'b0;
                                        sent_q  <= 1'b1;
                                    end else begin
                                        gap_q <= gap_q + 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign bus.laser_out  = laser_q;
    assign bus.busy       = busy_q;
    assign bus.packetsent = sent_q;
endmodule

// File: tb/tb_laser_tx.sv
module tb_laser_tx;
    localparam int          PW    = 288;
    localparam int          HB    = 2;
    localparam int          GB    = 2;
    localparam logic [15:0] HDR   = 16'hAA7E;
    localparam int          NBITS = 16 + PW + GB;
    localparam int          FRAME = NBITS * 2 * HB;   // 1224

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    laser_tx_if #(.PACKET_W(PW)) bus ();

    laser_tx #(.PACKET_W(PW), .HALF_BIT(HB), .HEADER(16'hAA7E), .GAP_BITS(GB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [PW-1:0] pkt;
        logic [PW-1:0] alt;
        bit            poke;
        int            exp_pulses;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [3:0] manch(input logic b);
        return b ? 4'b1100 : 4'b0011;
    endfunction

    // Called right after the accept edge t. Pushes the expected symbol stream,
    // then watches cycles t+1 .. t+FRAME+1.
    task automatic check_frame(input logic [PW-1:0] pkt, input bit poke,
                               input logic [PW-1:0] alt, input bit hold,
                               input int exp_pulses, input string tag);
        logic [3:0] nib;
        logic [3:0] e;
        int pulses;
        int busy_lo;
        int sym;
        exp_q.delete();
        for (int i = 15; i >= 0; i--) exp_q.push_back(manch(HDR[i]));
        for (int k = PW - 1; k >= 0; k--) exp_q.push_back(manch(pkt[k]));
        for (int g = 0; g < GB; g++) exp_q.push_back(4'b0000);
        nib = '0; pulses = 0; busy_lo = 0; sym = 0;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) bus.start = 1'b0;
            if (poke && c == 100) begin bus.start = 1'b1; bus.packet = alt; end
            if (poke && c == 101) bus.start = 1'b0;
            if (c == 1) chk({tag, " busy_first"}, 32'(bus.busy), 32'd1);
            nib = {nib[2:0], bus.laser_out};
            pulses += int'(bus.packetsent);
            busy_lo += int'(!bus.busy);
            if (c % 4 == 0) begin
                e = exp_q.pop_front();
                chk($sformatf("%s sym%0d", tag, sym), 32'(nib), 32'(e));
                sym++;
            end
        end
        chk({tag, " no_early_sent"}, 32'(pulses), 32'd0);
        chk({tag, " busy_held"}, 32'(busy_lo), 32'd0);
        @(negedge clk);
        pulses += int'(bus.packetsent);
        chk({tag, " sent_at_end"}, 32'(bus.packetsent), 32'd1);
        chk({tag, " busy_low_end"}, 32'(bus.busy), 32'd0);
        chk({tag, " pulse_count"}, 32'(pulses), 32'(exp_pulses));
        chk({tag, " sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [PW-1:0] pa, rp, q;
        int pulses, busy_hi;
        pa = {9{32'hA5A5_0F0F}};
        for (int w = 0; w < 9; w++) rp[w*32 +: 32] = $urandom;
        vecs[0] = '{pa, '0, 1'b0, 1};
        vecs[1] = '{{PW{1'b1}}, '0, 1'b0, 1};
        vecs[2] = '{{PW{1'b0}}, '0, 1'b0, 1};
        vecs[3] = '{pa, ~pa, 1'b1, 1};
        vecs[4] = '{rp, '0, 1'b0, 1};

        // Reset held with start high: outputs must stay low.
        reset = 1'b1; bus.start = 1'b1; bus.packet = pa;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_outs%0d", i),
                32'({bus.laser_out, bus.busy, bus.packetsent}), 32'd0);
        end
        reset = 1'b0;
        @(posedge clk);
        check_frame(pa, 1'b0, '0, 1'b0, 1, "post_rst");

        // Table-driven single frames.
        foreach (vecs[v]) begin
            @(negedge clk);
            bus.start = 1'b1; bus.packet = vecs[v].pkt;
            @(posedge clk);
            check_frame(vecs[v].pkt, vecs[v].poke, vecs[v].alt, 1'b0,
                        vecs[v].exp_pulses, $sformatf("vec%0d", v));
        end

        // Back-to-back: start held; second frame accepted on the pulse edge.
        @(negedge clk);
        bus.start = 1'b1; bus.packet = rp;
        @(posedge clk);
        check_frame(rp, 1'b0, '0, 1'b1, 1, "b2b_1");
        @(posedge clk);
        check_frame(rp, 1'b0, '0, 1'b0, 1, "b2b_2");

        // Reset mid-payload at t+300.
        @(negedge clk);
        bus.start = 1'b1; bus.packet = pa;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 2; c <= 300; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_laser", 32'(bus.laser_out), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_sent", 32'(bus.packetsent), 32'd0);
        reset = 1'b0;
        pulses = 0; busy_hi = 0;
        for (int c = 0; c < 1300; c++) begin
            @(negedge clk);
            pulses += int'(bus.packetsent);
            busy_hi += int'(bus.busy);
        end
        chk("midrst_no_pulse", 32'(pulses), 32'd0);
        chk("midrst_idle", 32'(busy_hi), 32'd0);
        q = ~rp;
        bus.start = 1'b1; bus.packet = q;
        @(posedge clk);
        check_frame(q, 1'b0, '0, 1'b0, 1, "after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
